// File: rtl/jtgng_rom_pkg.sv
// jtgng_rom_pkg: shared FSM states, widths and helpers for the ROM fetch scheduler
package jtgng_rom_pkg;
    localparam int SDRAM_AW = 22;
    localparam int DW = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_e;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/jtgng_rom_arb.sv
// jtgng_rom_arb: picks one pending slot, round-robin from ptr or fixed lowest-index priority
module jtgng_rom_arb
    import jtgng_rom_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int PRIO_MODE = 0,
    localparam int IW = idx_w(SLOTS)
) (
    input  logic [SLOTS-1:0] pend,
    input  logic [IW-1:0]    ptr,
    output logic [SLOTS-1:0] grant,
    output logic [IW-1:0]    win_idx,
    output logic [IW-1:0]    ptr_nxt
);
    logic found;
    int cand;
    always_comb begin
        found = 1'b0;
        cand = 0;
        win_idx = '0;
        for (int k = 0; k < SLOTS; k++) begin
            cand = PRIO_MODE != 0 ? k : (int'(ptr) + k) % SLOTS;
            if (!found && pend[cand]) begin
                found = 1'b1;
                win_idx = IW'(cand);
            end
        end
        grant = found ? SLOTS'(1) << win_idx : '0;
        ptr_nxt = int'(win_idx) == SLOTS - 1 ? '0 : win_idx + 1'b1;
    end
endmodule

// File: rtl/jtgng_rom_sched.sv
// jtgng_rom_sched: per-slot one-entry ROM caches refilled one at a time from a shared SDRAM read port
module jtgng_rom_sched
    import jtgng_rom_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW = 18,
    parameter int LATENCY = 2,
    parameter logic [SLOTS*SDRAM_AW-1:0] OFFSETS = '0,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS*DW-1:0]   slot_dout,
    output logic [SLOTS-1:0]      slot_ok,
    output logic                  sdram_re,
    output logic [SDRAM_AW-1:0]   sdram_addr,
    input  logic [DW-1:0]         data_read,
    output logic                  ready
);
    localparam int IW = idx_w(SLOTS);
    state_e state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, win_idx_q, win_idx_d;
    logic [AW-1:0] win_addr_q, win_addr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [SLOTS*AW-1:0] tag_q, tag_d;
    logic [SLOTS*DW-1:0] dout_q, dout_d;
    logic re_q, re_d, ready_q, ready_d;
    logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;
    logic [SLOTS-1:0] pend, grant;
    logic [IW-1:0] arb_idx, arb_ptr;
    logic [AW-1:0] sel_addr;
    logic [SDRAM_AW-1:0] sel_off;
    always_comb begin
        slot_ok = '0;
        for (int i = 0; i < SLOTS; i++)
            slot_ok[i] = slot_cs[i] & valid_q[i] & (tag_q[AW*i+:AW] == slot_addr[AW*i+:AW]);
    end
    assign pend = slot_cs & ~slot_ok;
    jtgng_rom_arb #(.SLOTS(SLOTS), .PRIO_MODE(PRIO_MODE)) u_arb (
        .pend    (pend),
        .ptr     (ptr_q),
        .grant   (grant),
        .win_idx (arb_idx),
        .ptr_nxt (arb_ptr)
    );
    assign sel_addr = slot_addr[AW*win_idx_q+:AW];
    assign sel_off = OFFSETS[SDRAM_AW*win_idx_q+:SDRAM_AW];
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        win_idx_d = win_idx_q;
        win_addr_d = win_addr_q;
        cnt_d = cnt_q;
        valid_d = valid_q;
        tag_d = tag_q;
        dout_d = dout_q;
        re_d = 1'b0;
        sdram_addr_d = sdram_addr_q;
        ready_d = ~downloading;
        case (state_q)
            IDLE: if (ready_q && !downloading && |grant) begin
                state_d = ISSUE;
                win_idx_d = arb_idx;
                ptr_d = arb_ptr;
            end
            // the strobe is registered so data_read lands exactly LATENCY cycles after it
            ISSUE: begin
                re_d = 1'b1;
                sdram_addr_d = sel_off + SDRAM_AW'(sel_addr);
                win_addr_d = sel_addr;
                cnt_d = 3'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                state_d = cnt_q == '0 ? CAPTURE : WAIT;
                cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            end
            CAPTURE: begin
                dout_d[DW*win_idx_q+:DW] = data_read;
                tag_d[AW*win_idx_q+:AW] = win_addr_q;
                valid_d[win_idx_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (downloading) begin
            state_d = IDLE;
            valid_d = '0;
            tag_d = tag_q;
            dout_d = dout_q;
            re_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            win_idx_q <= '0;
            win_addr_q <= '0;
            cnt_q <= '0;
            valid_q <= '0;
            tag_q <= '0;
            dout_q <= '0;
            re_q <= 1'b0;
            sdram_addr_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            win_idx_q <= win_idx_d;
            win_addr_q <= win_addr_d;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            tag_q <= tag_d;
            dout_q <= dout_d;
            re_q <= re_d;
            sdram_addr_q <= sdram_addr_d;
            ready_q <= ready_d;
        end
    end
    assign slot_dout = dout_q;
    assign sdram_re = re_q;
    assign sdram_addr = sdram_addr_q;
    assign ready = ready_q;
endmodule

// File: doc/jtgng_rom_sched.md
Name: jtgng_rom_sched

Overview:
- Parametrised SDRAM read scheduler for game cores; next generation of the fixed-slot ROM fetch unit between the game video/CPU ROM ports and the SDRAM controller.
- Serves SLOTS independent ROM clients, each with its own SDRAM base offset, a one-entry cache and a ready flag. Fetches come from a shared 32-bit SDRAM read port.
- Arbitration mode (round-robin or fixed priority) is selectable. Download handling invalidates all slots.

Parameters:
SLOTS, 4, number of ROM clients (1..8)
AW, 18, per-slot word address width (32-bit words)
LATENCY, 2, cycles from sdram_re high to valid data_read (1..7)
OFFSETS, 0, SLOTS*22-bit flat vector; slot i SDRAM base in bits [22*i+:22]
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (slot 0 highest)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
downloading  in  1  ROM download in progress; blocks and invalidates
slot_cs  in  SLOTS  per-slot request enable
slot_addr  in  SLOTS*AW  per-slot word address, slot i in [AW*i+:AW]
slot_dout  out  SLOTS*32  per-slot cached data word
slot_ok  out  SLOTS  slot data valid for the current slot_addr
sdram_re  out  1  one-cycle SDRAM read strobe
sdram_addr  out  22  SDRAM word address
data_read  in  32  SDRAM read data
ready  out  1  scheduler operational (no download, post-reset)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state to IDLE; all cache valid bits, slot_dout, sdram_re, sdram_addr and ready cleared to 0.
  - Round-robin pointer set to 0.
- Hit:
  - slot_ok[i] = slot_cs[i] & valid[i] & (tag[i]==slot_addr[i]). Combinational, zero latency on hit.
  - slot_cs low gives slot_ok low; cache contents are kept.
- Miss: pend[i] = slot_cs[i] & ~slot_ok[i], evaluated each cycle.
- FSM states:
  - IDLE: if ready and any pend, pick a winner, go to ISSUE.
    - PRIO_MODE 0: first pending slot at or after the pointer, wrapping SLOTS-1 to 0; pointer becomes winner+1 mod SLOTS.
    - PRIO_MODE 1: lowest-index pending slot.
  - ISSUE (1 cycle):
    - sdram_re=1 and sdram_addr = OFFSETS[i] + zero-extended slot_addr[i]. The sum wraps mod 2^22.
    - Latch win_addr and winner index; go to WAIT; latency counter = LATENCY-1.
  - WAIT: decrement counter; at 0 go to CAPTURE.
  - CAPTURE (1 cycle):
    - slot_dout[winner]=data_read, tag[winner]=win_addr, valid[winner]=1; go to IDLE.
    - slot_ok can rise the next cycle if the address is unchanged.
- Miss-to-ok latency: LATENCY+3 cycles from pend rising in IDLE to slot_ok high. LATENCY=2 gives 5 cycles.
- Only one request is outstanding at a time. sdram_re is never high on two consecutive cycles.
- Address changed mid-fetch:
  - The fetched data is still stored under win_addr.
  - The new address then misses, and a fresh fetch is scheduled through arbitration. No stale ok.
- Simultaneous CAPTURE for slot i and a new request from i: CAPTURE wins; the request is re-evaluated in IDLE.
- downloading=1:
  - Next cycle: ready=0, all valid cleared, FSM forced to IDLE, any outstanding fetch discarded with no CAPTURE write.
  - sdram_re forced 0.
- ready rises 1 cycle after downloading falls, only when rst=0.
- rst mid-fetch: same as the reset state; no write occurs.
- slot_dout is held when invalid. Consumers qualify it with slot_ok.

Decomposition:
- Shared package jtgng_rom_pkg: FSM state enum (IDLE, ISSUE, WAIT, CAPTURE), SDRAM address width constant (22), data width constant (32).
- One sub-module: jtgng_rom_arb. Pure arbiter taking pend, pointer and PRIO_MODE, returning a one-hot winner, an index and the next pointer. It is kept separate so it can be unit-tested.
- Cache/tag registers and the FSM stay in jtgng_rom_sched.

Test Plan:
- Reset, then slot0 cs=1, addr=0x00010, OFFSETS[0]=0x10000, LATENCY=2 -> sdram_re pulses once with sdram_addr=0x10010. Data_read=0xDEADBEEF is captured; slot_ok[0]=1 exactly 5 cycles after the request, slot_dout[0]=0xDEADBEEF.
- Same address held, cs toggled 1->0->1 -> no further sdram_re; slot_ok[0] follows cs with zero latency.
- PRIO_MODE 0, all 4 slots miss simultaneously -> issue order 0,1,2,3. Then slots 0 and 3 miss again with pointer=0 -> order 0,3.
- PRIO_MODE 1, slots 1 and 2 miss repeatedly (address increments after each ok) -> slot 2 is served only when slot 1 is not pending.
- Slot1 address changes 0x20->0x21 during WAIT -> the 0x20 data is stored but slot_ok[1] stays 0. A second sdram_re follows for the 0x21 address; ok rises after its capture.
- downloading pulsed high during WAIT -> ready=0 next cycle, all slot_ok=0, no capture write. ready=1 one cycle after downloading falls, and pending slots refetch.
